// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and
// a helper that classifies the iterative operations.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIVU = 4'd4;
    localparam logic [3:0] ALU_REMU = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_SNE  = 4'd11;
    localparam logic [3:0] ALU_NOR  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // True for the op codes handled by the iterative datapath.
    function automatic logic is_iter_op(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIVU) || (ctrl == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply / divide datapath. One bit per clock:
// shift-add for MUL, restoring shift-subtract for DIVU/REMU.
// go_i loads the operands; run_i advances one iteration; fin_o marks the
// last iteration, during which res_o already carries the final value.
module alu_mc_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic             run_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             fin_o,
    output logic [WIDTH-1:0] res_o
);

    // acc: product accumulator (MUL) or partial remainder (DIV/REM).
    // opa: shifted multiplicand (MUL) or dividend shifting into quotient.
    // opb: multiplier shifting right (MUL) or fixed divisor (DIV/REM).
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt;
    logic [CNT_W-1:0] cnt;
    logic             mode_mul, mode_rem;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    // One iteration step, computed from the current registers.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_nxt = acc;
        opa_nxt = opa;
        opb_nxt = opb;
        rem_sh  = {acc, opa[WIDTH-1]};
        ge      = rem_sh >= {1'b0, opb};
        if (mode_mul) begin
            acc_nxt = acc + (opb[0] ? opa : '0);
            opa_nxt = opa << 1;
            opb_nxt = opb >> 1;
        end else begin
            // The true difference is below the divisor when ge, so the low WIDTH bits suffice.
            acc_nxt = ge ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];
            opa_nxt = {opa[WIDTH-2:0], ge};
        end
    end

    assign fin_o = run_i && (cnt == CNT_W'(WIDTH - 1));
    assign res_o = (mode_mul || mode_rem) ? acc_nxt : opa_nxt;

    // Operand load on go, one iteration per clock while running.
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            cnt      <= '0;
            mode_mul <= 1'b0;
            mode_rem <= 1'b0;
        end else if (go_i) begin
            acc      <= '0;
            opa      <= src1_i;
            opb      <= src2_i;
            cnt      <= '0;
            mode_mul <= (ctrl_i == ALU_MUL);
            mode_rem <= (ctrl_i == ALU_REMU);
        end else if (run_i) begin
            acc <= acc_nxt;
            opa <= opa_nxt;
            opb <= opb_nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops and
// divide-by-zero finish in one clock; MUL/DIVU/REMU run WIDTH iterations
// in alu_mc_iter. result_o and zero_o are registered together.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] quick_res, iter_res;
    logic             go, iter_fin, load_quick, load_iter, div_zero;

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .go_i   (go),
        .run_i  (state == S_RUN),
        .ctrl_i (ctrl_i),
        .src1_i (src1_i),
        .src2_i (src2_i),
        .fin_o  (iter_fin),
        .res_o  (iter_res)
    );

    assign div_zero = ((ctrl_i == ALU_DIVU) || (ctrl_i == ALU_REMU)) && (src2_i == '0);

    // Single-cycle results; DIVU/REMU entries only apply when B is zero.
    always_comb begin
        quick_res = '0;
        case (ctrl_i)
            ALU_AND:  quick_res = src1_i & src2_i;
            ALU_OR:   quick_res = src1_i | src2_i;
            ALU_ADD:  quick_res = src1_i + src2_i;
            ALU_SUB:  quick_res = src1_i - src2_i;
            ALU_NOR:  quick_res = ~(src1_i | src2_i);
            ALU_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            ALU_SRA:  quick_res = $signed(src2_i) >>> src1_i[SH_W-1:0];
            ALU_LUI:  quick_res = src2_i << (WIDTH / 2);
            ALU_SNE:  quick_res = {{(WIDTH-1){1'b0}}, (src1_i != src2_i)};
            ALU_DIVU: quick_res = '1;
            ALU_REMU: quick_res = src1_i;
            default:  quick_res = '0;
        endcase
    end

    // Next-state and load strobes; a new op is accepted in IDLE or DONE.
    always_comb begin
        state_nxt  = state;
        go         = 1'b0;
        load_quick = 1'b0;
        load_iter  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start_i) begin
                    if (is_iter_op(ctrl_i) && !div_zero) begin
                        go        = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        load_quick = 1'b1;
                        state_nxt  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (iter_fin) begin
                    load_iter = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Result and zero flag, always written on the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
        end else if (load_quick) begin
            result_o <= quick_res;
            zero_o   <= (quick_res == '0);
        end else if (load_iter) begin
            result_o <= iter_res;
            zero_o   <= (iter_res == '0);
        end
    end

    assign busy_o = (state == S_RUN);
    assign done_o = (state == S_DONE);

endmodule
